// File: rtl/truth_table_checker.sv
// Exhaustive-vector response checker: sweeps all 2**N_IN inputs, samples f, compares to EXPECTED.
// Optional build macro TTC_STOP_ON_ERR_EN ends the sweep at the first mismatching vector.
module truth_table_checker #(
    parameter int                  N_IN     = 4,
    parameter int                  SETTLE   = 2,
    parameter logic [2**N_IN-1:0]  EXPECTED = 16'hE8A0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      x,
    input  logic                 f,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_idx,
    output logic                 first_err_valid
);

    localparam int NV    = 2**N_IN;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [NV-1:0]     captured_q, captured_d;
    logic [N_IN:0]     err_count_q, err_count_d;
    logic [N_IN-1:0]   first_err_idx_q, first_err_idx_d;
    logic              first_err_valid_q, first_err_valid_d;
    logic              mismatch;
    logic              last_vec;
    logic              stop_sweep;

    assign mismatch = (f != EXPECTED[idx_q]);
    assign last_vec = (idx_q == N_IN'(NV - 1));

`ifdef TTC_STOP_ON_ERR_EN
    assign stop_sweep = last_vec || mismatch;
`else
    assign stop_sweep = last_vec;
`endif

    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        cnt_d             = cnt_q;
        busy_d            = busy_q;
        done_d            = 1'b0;
        pass_d            = pass_q;
        captured_d        = captured_q;
        err_count_d       = err_count_q;
        first_err_idx_d   = first_err_idx_q;
        first_err_valid_d = first_err_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    captured_d        = '0;
                    err_count_d       = '0;
                    first_err_idx_d   = '0;
                    first_err_valid_d = 1'b0;
                    pass_d            = 1'b0;
                    idx_d             = '0;
                    cnt_d             = CNT_W'(SETTLE - 1);
                    busy_d            = 1'b1;
                    state_d           = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SAMPLE: begin
                captured_d[idx_q] = f;
                if (mismatch) begin
                    err_count_d = err_count_q + 1'b1;
                    if (!first_err_valid_q) begin
                        first_err_idx_d   = idx_q;
                        first_err_valid_d = 1'b1;
                    end
                end
                if (stop_sweep) begin
                    state_d = S_DONE;
                end else begin
                    // x follows idx, so the next vector appears on the WAIT entry edge
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = CNT_W'(SETTLE - 1);
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_count_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            idx_q             <= '0;
            cnt_q             <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            captured_q        <= '0;
            err_count_q       <= '0;
            first_err_idx_q   <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            cnt_q             <= cnt_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            captured_q        <= captured_d;
            err_count_q       <= err_count_d;
            first_err_idx_q   <= first_err_idx_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    assign x               = idx_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign captured        = captured_q;
    assign err_count       = err_count_q;
    assign first_err_idx   = first_err_idx_q;
    assign first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: ideal, stuck-at-0 and stuck-at-1 functions, start handling, mid-sweep reset.
module tb_truth_table_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  x;
    logic        f;
    logic        busy, done, pass;
    logic [15:0] captured;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic        first_err_valid;

    logic [15:0] exp_tbl = 16'hE8A0;
    int          mode = 0;   // 0: ideal function, 1: stuck at 0, 2: stuck at 1
    int          checks = 0;
    int          errors = 0;

    assign f = (mode == 0) ? exp_tbl[x] : ((mode == 1) ? 1'b0 : 1'b1);

    truth_table_checker dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .x               (x),
        .f               (f),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .captured        (captured),
        .err_count       (err_count),
        .first_err_idx   (first_err_idx),
        .first_err_valid (first_err_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pulses start, then reports the cycle (counted from the start edge) at which done is seen.
    task automatic sweep(input int pulse_at, input int hold_from,
                         output int done_cyc, output int x_bad, output logic busy0);
        done_cyc = -1;
        x_bad    = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        busy0 = busy;
        start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cyc = k;
                break;
            end
            if ((k % 3) != 0 && x !== 4'(k / 3)) x_bad++;
            start = (k == pulse_at) || (hold_from != 0 && k >= hold_from);
        end
    endtask

    initial begin
        int   dc;
        int   xb;
        logic b0;
        int   done_seen;
        int   found;

        // 1: reset held, then idle without start
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {x, busy, done, pass, captured, err_count, first_err_idx, first_err_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("idle_no_done", done_seen, 0);
        check("idle_outputs", {x, busy, done, pass, captured, err_count, first_err_idx, first_err_valid}, 64'd0);

        // 2: ideal function
        mode = 0;
        sweep(0, 0, dc, xb, b0);
        $display("sweep ideal: done_cyc=%0d captured=%h err=%0d pass=%0b", dc, captured, err_count, pass);
        check("ideal_busy_after_start", b0, 1);
        check("ideal_done_cycle", dc, 49);
        check("ideal_x_steps", xb, 0);
        check("ideal_captured", captured, 16'hE8A0);
        check("ideal_err_count", err_count, 0);
        check("ideal_pass", pass, 1);
        check("ideal_first_valid", first_err_valid, 0);
        check("ideal_busy_at_done", busy, 0);
        @(posedge clk);
        #1;
        check("ideal_done_one_cycle", done, 0);

        // 3: stuck at 0
        mode = 1;
        sweep(0, 0, dc, xb, b0);
        $display("sweep f=0: done_cyc=%0d captured=%h err=%0d first=%0d pass=%0b", dc, captured, err_count, first_err_idx, pass);
        check("zero_x_steps", xb, 0);
        check("zero_captured", captured, 16'h0000);
        check("zero_first_idx", first_err_idx, 5);
        check("zero_first_valid", first_err_valid, 1);
        check("zero_pass", pass, 0);
`ifdef TTC_STOP_ON_ERR_EN
        check("zero_done_cycle", dc, 19);
        check("zero_err_count", err_count, 1);
        check("zero_x_hold", x, 5);
`else
        check("zero_done_cycle", dc, 49);
        check("zero_err_count", err_count, 6);
        check("zero_x_hold", x, 15);
`endif

        // stuck at 1
        mode = 2;
        sweep(0, 0, dc, xb, b0);
        $display("sweep f=1: done_cyc=%0d captured=%h err=%0d first=%0d pass=%0b", dc, captured, err_count, first_err_idx, pass);
        check("one_first_idx", first_err_idx, 0);
        check("one_first_valid", first_err_valid, 1);
        check("one_pass", pass, 0);
`ifdef TTC_STOP_ON_ERR_EN
        check("one_done_cycle", dc, 4);
        check("one_err_count", err_count, 1);
        check("one_captured", captured, 16'h0001);
`else
        check("one_done_cycle", dc, 49);
        check("one_err_count", err_count, 10);
        check("one_captured", captured, 16'hFFFF);
`endif

        // 4: start pulse mid-sweep is ignored
        mode = 0;
        sweep(10, 0, dc, xb, b0);
        $display("sweep ideal with start at idx 3: done_cyc=%0d pass=%0b", dc, pass);
        check("restart_ignored_done_cycle", dc, 49);
        check("restart_ignored_pass", pass, 1);

        // start held through DONE relaunches on the edge after IDLE entry
        sweep(0, 47, dc, xb, b0);
        $display("sweep ideal with start held: done_cyc=%0d pass=%0b", dc, pass);
        check("hold_done_cycle", dc, 49);
        check("hold_pass_at_done", pass, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold_relaunch_busy", busy, 1);
        check("hold_relaunch_pass_cleared", pass, 0);
        check("hold_relaunch_x", x, 0);
        found = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                found = k;
                break;
            end
        end
        $display("relaunched sweep: done_cyc=%0d pass=%0b", found, pass);
        check("hold_relaunch_done_cycle", found, 49);
        check("hold_relaunch_captured", captured, 16'hE8A0);

        // 5: asynchronous reset while x=7
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (x == 4'd7) begin
                found = 1;
                break;
            end
        end
        check("reset_x7_reached", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset at x=7: busy=%0b x=%0d captured=%h", busy, x, captured);
        check("async_reset_outputs", {x, busy, done, pass, captured, err_count, first_err_idx, first_err_valid}, 64'd0);
        done_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("async_reset_no_done", done_seen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, 0, dc, xb, b0);
        $display("sweep after reset: done_cyc=%0d captured=%h err=%0d pass=%0b", dc, captured, err_count, pass);
        check("post_reset_done_cycle", dc, 49);
        check("post_reset_captured", captured, 16'hE8A0);
        check("post_reset_err_count", err_count, 0);
        check("post_reset_pass", pass, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
